dftprobe_shift_capture: RTL and testbench
=========================================

// Module: dftprobe_shift_capture
// PURPOSE
//  Multi-channel successor to the single-bit tdi probe cell: samples NCH asynchronous status
//  lines, captures a snapshot on request while test enable is high, and serialises it onto one
//  tdi pin, LSB first. Sits between analog status sources (e.g. switch status) and the ATE scan path.
//  Functional path: synchronised status remains available on o at all times.
// PARAMETERS
//  NCH          8   number of probed status channels (1..32)
//  SYNC_STAGES  2   synchroniser flops per channel (>=2)
//  CNT_W        6   shift counter width; must satisfy 2^CNT_W > NCH+1
// PORTS
//  clk       in   1         single clock, all state on rising edge
//  rst       in   1         asynchronous, active-high reset
//  i         in   NCH       asynchronous status inputs
//  ten       in   1         test enable; level, synchronous to clk
//  cap_req   in   1         capture request; one-cycle pulse, sampled only when ten=1
//  o         out  NCH       synchronised copy of i (functional observe path)
//  tdi       out  1         serial probe data
//  tdi_vld   out  1         high on each cycle tdi carries a valid bit
//  busy      out  1         high in CAPTURE or SHIFT
//  done      out  1         one-cycle pulse after the last bit is shifted
// BEHAVIOUR
//  Reset: all synchroniser flops, o, shadow reg, counter = 0; tdi=0, tdi_vld=0, busy=0, done=0;
//   state=IDLE. Reset may assert at any cycle, including mid-shift; outputs go to reset values
//   immediately (asynchronously).
//  Sync: o = i delayed SYNC_STAGES clocks; no filtering.
//  FSM: IDLE -> CAPTURE when ten=1 and cap_req=1; CAPTURE -> SHIFT (next cycle); SHIFT -> DONE
//   after the last bit; DONE -> IDLE (next cycle).
//  CAPTURE (1 cycle): shadow <= o; counter <= 0; busy=1, tdi_vld=0.
//  SHIFT: tdi = shadow[counter], tdi_vld=1; counter increments each cycle. Frame length is
//   NBITS = NCH (NCH+1 with parity); SHIFT lasts exactly NBITS cycles.
//  Latency: first valid bit appears 2 cycles after the cap_req cycle, i.e. cap_req at T gives
//   CAPTURE at T+1 and bit0 at T+2.
//  DONE: done=1, busy=0, tdi=0, tdi_vld=0 for one cycle.
//  ten=0 in any non-IDLE state: abort to IDLE on the next edge. tdi=0, tdi_vld=0, no done pulse,
//   and the shadow register keeps its value.
//  ten=0 in IDLE: tdi held 0 (gated probe, as in the single-bit cell).
//  cap_req while busy or in DONE: ignored, not queued.
//  cap_req coincident with ten rising (both first seen 1 in the same cycle): accepted.
//  tdi and tdi_vld are registered outputs; no combinational path from i or ten.
// CONFIGURATION
//  DFTPROBE_PARITY_EN defined: after bit NCH-1, one extra SHIFT cycle drives the even parity
//   bit (XOR of the captured shadow) with tdi_vld=1; NBITS=NCH+1.
//  Not defined: no parity cycle; NBITS=NCH; no parity logic is synthesised.
// TESTING
//  1 Reset: rst=1 with random i, ten=1 -> o=0, tdi=0, tdi_vld=0, busy=0, done=0; release
//    rst, i=8'hA5 -> o=8'hA5 after 2 clocks.
//  2 Capture, NCH=8, i=8'hA5, ten=1, cap_req at T -> tdi_vld high T+2..T+9, tdi=1,0,1,0,0,1,0,1;
//    done=1 at T+10.
//  3 Parity build, i=8'h07 -> 9 valid bits: 1,1,1,0,0,0,0,0 then parity 1; done at T+11.
//    Default build, same stimulus -> only 8 bits.
//  4 Abort: drop ten at the 4th shift bit -> next cycle tdi=0, tdi_vld=0, busy=0; no done;
//    a new cap_req after ten=1 again restarts from bit0.
//  5 Ignore: cap_req during SHIFT and in the DONE cycle -> frame unchanged, no second frame;
//    cap_req with ten=0 -> state stays IDLE.
//  6 Async reset mid-SHIFT (bit 3) -> outputs zero the same cycle, FSM in IDLE, o cleared.

Source files
------------

// File: rtl/dftprobe_shift_capture.sv
// Multi-channel DFT probe: synchronises NCH status lines, snapshots them on request and
// shifts the snapshot out on tdi LSB first. Define DFTPROBE_PARITY_EN to append an even-parity bit.
module dftprobe_shift_capture #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] i,
  input  logic           ten,
  input  logic           cap_req,
  output logic [NCH-1:0] o,
  output logic           tdi,
  output logic           tdi_vld,
  output logic           busy,
  output logic           done
);

`ifdef DFTPROBE_PARITY_EN
  localparam int NBITS = NCH + 1;
`else
  localparam int NBITS = NCH;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} state_t;

  state_t                              state_reg;
  logic [SYNC_STAGES-1:0][NCH-1:0]     sync_reg;
  logic [NCH-1:0]                      shadow_reg;
  logic [CNT_W-1:0]                    cnt_reg;
  logic [CNT_W-1:0]                    nxt_idx;
  logic [NCH-1:0]                      shifted;
  logic                                nxt_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], i};
    end
  end

  assign o = sync_reg[SYNC_STAGES-1];

  // tdi is registered, so each cycle loads the bit that will be visible next cycle
  assign nxt_idx = cnt_reg + 1'b1;
  assign shifted = shadow_reg >> nxt_idx;
`ifdef DFTPROBE_PARITY_EN
  assign nxt_bit = (nxt_idx == CNT_W'(NCH)) ? ^shadow_reg : shifted[0];
`else
  assign nxt_bit = shifted[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      shadow_reg <= '0;
      cnt_reg    <= '0;
      tdi        <= 1'b0;
      tdi_vld    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tdi     <= 1'b0;
      tdi_vld <= 1'b0;
      done    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ten && cap_req) begin
            state_reg <= CAPTURE;
            busy      <= 1'b1;
          end
        end
        CAPTURE: begin
          if (!ten) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            shadow_reg <= o;
            cnt_reg    <= '0;
            tdi        <= o[0];
            tdi_vld    <= 1'b1;
            state_reg  <= SHIFT;
          end
        end
        SHIFT: begin
          if (!ten) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if (cnt_reg == LAST_IDX) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt_reg <= nxt_idx;
            tdi     <= nxt_bit;
            tdi_vld <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dftprobe_shift_capture.sv
// Scoreboard bench for dftprobe_shift_capture: a frame-level model queues the expected
// per-cycle output events, and a negedge monitor compares them against the DUT.
module tb_dftprobe_shift_capture;

  localparam int NCH = 8;
`ifdef DFTPROBE_PARITY_EN
  localparam int NBITS = NCH + 1;
`else
  localparam int NBITS = NCH;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] out;   // {busy, tdi_vld, tdi, done}
  } ev_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] i = '0;
  logic           ten = 1'b1;
  logic           cap_req = 1'b0;
  logic [NCH-1:0] o;
  logic           tdi, tdi_vld, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_until = -1;
  int frame_t = -100;
  ev_t sb[$];
  logic [NCH-1:0] i_hist [int];

  dftprobe_shift_capture #(.NCH(NCH), .SYNC_STAGES(2), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .i(i), .ten(ten), .cap_req(cap_req),
    .o(o), .tdi(tdi), .tdi_vld(tdi_vld), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, exp);
    end else begin
      $display("ok   %s cyc=%0d value=%0h", name, cyc, got);
    end
  endtask

  // Frame model: snapshot is the input two cycles before capture (o lags i by two clocks).
  task automatic push_frame();
    logic [NCH-1:0] snap;
    logic [NCH-1:0] sh;
    logic           b;
    snap = i_hist[cyc-1];
    sb.push_back(ev_t'{cyc + 1, 4'b1000});
    for (int k = 0; k < NBITS; k++) begin
      sh = snap >> k;
      b  = (k < NCH) ? sh[0] : ^snap;
      sb.push_back(ev_t'{cyc + 2 + k, {2'b11, b, 1'b0}});
    end
    sb.push_back(ev_t'{cyc + 2 + NBITS, 4'b0001});
    frame_t    = cyc;
    busy_until = cyc + 2 + NBITS;
  endtask

  task automatic step(input logic [NCH-1:0] iv, input logic t, input logic c);
    @(posedge clk);
    #1;
    i       = iv;
    ten     = t;
    cap_req = c;
    i_hist[cyc] = iv;
    // ten low during capture or shift: everything after this cycle is dropped
    if (!t && cyc > frame_t && cyc < busy_until) begin
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      busy_until = cyc;
    end
    if (t && c && !rst && cyc > busy_until) push_frame();
  endtask

  always @(negedge clk) begin
    logic [3:0] obs;
    ev_t e;
    obs = {busy, tdi_vld, tdi, done};
    if (obs != 4'b0000 || (sb.size() > 0 && sb[0].cyc <= cyc)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output cyc=%0d got=%b required=idle", cyc, obs);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.out != obs) begin
          miscompares++;
          $display("FAIL frame_event cyc=%0d got=%b required=%b@cyc%0d", cyc, obs, e.out, e.cyc);
        end else begin
          $display("ok   frame_event cyc=%0d out=%b", cyc, obs);
        end
      end
    end
  end

  initial begin
    int r;
    // reset with random inputs and test enable high
    repeat (3) step(NCH'($urandom), 1'b1, 1'b0);
    chk("rst_o", 32'(o), 32'h0);
    chk("rst_tdi", 32'(tdi), 32'h0);
    chk("rst_tdi_vld", 32'(tdi_vld), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    step(8'hA5, 1'b1, 1'b0);
    rst = 1'b0;
    r = cyc;
    step(8'hA5, 1'b1, 1'b0);
    chk("sync_lag1", 32'(o), 32'h0);
    step(8'hA5, 1'b1, 1'b0);
    chk("sync_lag2", 32'(o), 32'hA5);

    // basic frame of 8'hA5
    step(8'hA5, 1'b1, 1'b1);
    repeat (NBITS + 4) step(8'hA5, 1'b1, 1'b0);

    // frame of 8'h07 (parity bit 1 when enabled)
    repeat (3) step(8'h07, 1'b1, 1'b0);
    step(8'h07, 1'b1, 1'b1);
    repeat (NBITS + 4) step(8'h07, 1'b1, 1'b0);

    // abort at bit 3, then restart from bit 0
    repeat (3) step(8'h3C, 1'b1, 1'b0);
    step(8'h3C, 1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) step(8'h3C, (k < 5), 1'b0);
    step(8'h3C, 1'b1, 1'b1);
    repeat (NBITS + 4) step(8'h3C, 1'b1, 1'b0);

    // cap_req during shift and in the done cycle, then with ten low
    repeat (3) step(8'h96, 1'b1, 1'b0);
    step(8'h96, 1'b1, 1'b1);
    for (int k = 1; k <= NBITS + 4; k++) step(8'h69, 1'b1, (k == 3) || (k == NBITS + 2));
    repeat (4) step(8'h55, 1'b0, 1'b1);
    repeat (3) step(8'h55, 1'b1, 1'b0);

    // asynchronous reset in the middle of bit 3
    step(8'hC3, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) step(8'hC3, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    sb.delete();
    busy_until = cyc;
    #1;
    chk("arst_tdi", 32'(tdi), 32'h0);
    chk("arst_tdi_vld", 32'(tdi_vld), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_o", 32'(o), 32'h0);
    step(8'hC3, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (3) step(8'hC3, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 800; n++)
      step(NCH'($urandom), ($urandom_range(0, 24) != 0), ($urandom_range(0, 4) == 0));

    repeat (NBITS + 6) step(NCH'($urandom), 1'b1, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
